// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a single-line burst refill port.
// Optional ICACHE_INVALIDATE_EN adds INV_SI to clear all valid bits.
module icache_direct #(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ADR_SI,
    input  logic        ADR_VALID_SI,
`ifdef ICACHE_INVALIDATE_EN
    input  logic        INV_SI,
`endif
    output logic [31:0] IC_INST_SI,
    output logic        IC_STALL_SI,
    output logic [31:0] MEM_ADR_SI,
    output logic        MEM_REQ_SI,
    input  logic        MEM_ACK_SM,
    input  logic [31:0] MEM_DATA_SM,
    input  logic        MEM_DATA_VALID_SM
);

    localparam int unsigned WRD_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned OFS_W = WRD_W + 2;
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 32 - IDX_W - OFS_W;
    localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS_PER_LINE - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;

    state_e                 state_q, state_d;
    logic [WRD_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            ref_adr_q, ref_adr_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [31:0]            data_q [NUM_LINES][WORDS_PER_LINE];
    logic                   inv_pend_q, inv_pend_d;
    logic                   inv_c;

    logic [TAG_W-1:0]       adr_tag;
    logic [IDX_W-1:0]       adr_idx;
    logic [WRD_W-1:0]       adr_wrd;
    logic [TAG_W-1:0]       ref_tag;
    logic [IDX_W-1:0]       ref_idx;
    logic                   hit_c;
    logic                   miss_c;
    logic                   beat_c;
    logic                   fill_done_c;
    logic                   unused_c;

`ifdef ICACHE_INVALIDATE_EN
    assign inv_c = INV_SI;
`else
    assign inv_c = 1'b0;
`endif

    // Fetch and refill address decode
    assign adr_tag  = ADR_SI[31 -: TAG_W];
    assign adr_idx  = ADR_SI[OFS_W +: IDX_W];
    assign adr_wrd  = ADR_SI[2 +: WRD_W];
    assign ref_tag  = ref_adr_q[31 -: TAG_W];
    assign ref_idx  = ref_adr_q[OFS_W +: IDX_W];
    assign unused_c = ^ADR_SI[1:0];

    assign hit_c       = valid_q[adr_idx] && (tag_q[adr_idx] == adr_tag) && (state_q == IDLE);
    assign miss_c      = ADR_VALID_SI && !hit_c;
    assign beat_c      = (state_q == FILL) && MEM_DATA_VALID_SM;
    assign fill_done_c = beat_c && (cnt_q == LAST_BEAT);

    // State register and control flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ref_adr_q  <= '0;
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_adr_q  <= ref_adr_d;
            valid_q    <= valid_d;
            inv_pend_q <= inv_pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_adr_d  = ref_adr_q;
        valid_d    = valid_q;
        inv_pend_d = inv_pend_q;
        case (state_q)
            IDLE: begin
                if (inv_c) begin
                    valid_d = '0;
                end
                if (miss_c) begin
                    ref_adr_d        = {ADR_SI[31:OFS_W], OFS_W'(0)};
                    valid_d[adr_idx] = 1'b0;
                    state_d          = REQ;
                end
            end
            REQ: begin
                if (inv_c) begin
                    inv_pend_d = 1'b1;
                end
                if (MEM_ACK_SM) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (inv_c) begin
                    inv_pend_d = 1'b1;
                end
                if (beat_c) begin
                    cnt_d = WRD_W'(cnt_q + 1'b1);
                end
                if (fill_done_c) begin
                    // A pending invalidate also wipes the line just filled
                    if (inv_pend_q || inv_c) begin
                        valid_d = '0;
                    end else begin
                        valid_d[ref_idx] = 1'b1;
                    end
                    inv_pend_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch-side and memory-request outputs
    always_comb begin
        IC_INST_SI  = NOP;
        IC_STALL_SI = ADR_VALID_SI && !hit_c;
        MEM_REQ_SI  = (state_q == REQ);
        if (hit_c) begin
            IC_INST_SI = data_q[adr_idx][adr_wrd];
        end
    end

    assign MEM_ADR_SI = ref_adr_q;

    // Tag and data arrays are not reset; valid_q guards them
    always_ff @(posedge clk) begin
        if (beat_c) begin
            data_q[ref_idx][cnt_q] <= MEM_DATA_SM;
        end
        if (fill_done_c) begin
            tag_q[ref_idx] <= ref_tag;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus random fetches
// against a transparent-memory cache model.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] adr;
    logic        adr_valid;
    logic [31:0] inst;
    logic        stall;
    logic [31:0] mem_adr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        mem_dv;
`ifdef ICACHE_INVALIDATE_EN
    logic        inv;
`endif

    int total = 0;
    int bad   = 0;

    bit          m_valid [16];
    logic [23:0] m_tag   [16];

    icache_direct dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ADR_SI           (adr),
        .ADR_VALID_SI     (adr_valid),
`ifdef ICACHE_INVALIDATE_EN
        .INV_SI           (inv),
`endif
        .IC_INST_SI       (inst),
        .IC_STALL_SI      (stall),
        .MEM_ADR_SI       (mem_adr),
        .MEM_REQ_SI       (mem_req),
        .MEM_ACK_SM       (mem_ack),
        .MEM_DATA_SM      (mem_data),
        .MEM_DATA_VALID_SM(mem_dv)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h0001_0001) ^ 32'hA0A0_A0A0;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        adr_valid = 1'b0;
        mem_ack   = 1'b0;
        mem_dv    = 1'b0;
        m_clear();
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One fetch; on a miss, plays the memory side with given ACK delay and beat gaps
    task automatic fetch(input logic [31:0] a, input int ack_d, input int gap,
                         input bit use_redir, input logic [31:0] redir, input bit inv_mid);
        logic [31:0] line;
        bit          h;
        line      = {a[31:4], 4'h0};
        adr       = a;
        adr_valid = 1'b1;
        #1;
        h = m_hit(a);
        chk("lookup_stall", 32'(stall), 32'(!h));
        if (h) begin
            chk("hit_inst", inst, mem_fn(a));
            chk("hit_noreq", 32'(mem_req), 32'd0);
            step();
            return;
        end
        step();
        for (int i = 0; i < ack_d; i++) begin
            chk("req_wait", 32'(mem_req), 32'd1);
            chk("req_adr", mem_adr, line);
            chk("req_stall", 32'(stall), 32'd1);
            step();
        end
        chk("req_ack", 32'(mem_req), 32'd1);
        chk("req_ack_adr", mem_adr, line);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("fill_noreq", 32'(mem_req), 32'd0);
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
                chk("gap_stall", 32'(stall), 32'd1);
                step();
            end
            if (use_redir && w == 2) adr = redir;
            chk("fill_stall", 32'(stall), 32'd1);
            mem_dv   = 1'b1;
            mem_data = mem_fn(line + 32'(4 * w));
`ifdef ICACHE_INVALIDATE_EN
            inv = inv_mid && (w == 1);
`endif
            step();
            mem_dv = 1'b0;
`ifdef ICACHE_INVALIDATE_EN
            inv = 1'b0;
`endif
        end
        if (inv_mid) begin
            m_clear();
        end else begin
            m_valid[line[7:4]] = 1'b1;
            m_tag[line[7:4]]   = line[31:8];
        end
        h = m_hit(adr);
        chk("done_stall", 32'(stall), 32'(!h));
        if (h) begin
            chk("done_inst", inst, mem_fn(adr));
            step();
        end
    endtask

    initial begin
        logic [31:0] ra;
        adr      = '0;
        mem_data = '0;
`ifdef ICACHE_INVALIDATE_EN
        inv = 1'b0;
`endif
        do_reset();
        chk("rst_adr", mem_adr, 32'd0);

        // Cold miss, then same-line hits
        fetch(32'h100, 0, 0, 1'b0, 32'h0, 1'b0);
        fetch(32'h10C, 0, 0, 1'b0, 32'h0, 1'b0);
        fetch(32'h104, 0, 0, 1'b0, 32'h0, 1'b0);

        // Conflict eviction on index 0
        fetch(32'h1100, 0, 0, 1'b0, 32'h0, 1'b0);
        fetch(32'h100, 0, 0, 1'b0, 32'h0, 1'b0);
        fetch(32'h1104, 0, 0, 1'b0, 32'h0, 1'b0);

        // Slow ACK and gapped beats
        fetch(32'h3208, 5, 2, 1'b0, 32'h0, 1'b0);

        // Redirect mid-fill: line completes, new address misses afterwards
        fetch(32'h5100, 1, 0, 1'b1, 32'h200, 1'b0);
        fetch(32'h200, 0, 0, 1'b0, 32'h0, 1'b0);
        fetch(32'h5104, 0, 0, 1'b0, 32'h0, 1'b0);

        // Fetch valid low never stalls
        adr_valid = 1'b0;
        adr = 32'hDEAD_0000;
        #1 chk("novalid_stall", 32'(stall), 32'd0);
        step();

        // Reset in the middle of a fill
        adr = 32'h7100;
        adr_valid = 1'b1;
        step();
        chk("mid_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        mem_dv = 1'b1;
        mem_data = 32'h1111_1111;
        step();
        mem_dv = 1'b0;
        reset_n = 1'b0;
        adr_valid = 1'b0;
        m_clear();
        #1 chk("midrst_req", 32'(mem_req), 32'd0);
        step();
        reset_n = 1'b1;
        fetch(32'h100, 0, 0, 1'b0, 32'h0, 1'b0);
        fetch(32'h7100, 0, 1, 1'b0, 32'h0, 1'b0);

`ifdef ICACHE_INVALIDATE_EN
        // Invalidate in IDLE: same-cycle hit still served
        fetch(32'h100, 0, 0, 1'b0, 32'h0, 1'b0);
        adr = 32'h104;
        inv = 1'b1;
        #1;
        chk("inv_hit_stall", 32'(stall), 32'd0);
        chk("inv_hit_inst", inst, mem_fn(32'h104));
        step();
        inv = 1'b0;
        m_clear();
        fetch(32'h104, 0, 0, 1'b0, 32'h0, 1'b0);
        // Invalidate during fill: completed line still misses
        fetch(32'h300, 0, 0, 1'b0, 32'h0, 1'b1);
        fetch(32'h300, 0, 0, 1'b0, 32'h0, 1'b0);
        fetch(32'h304, 0, 0, 1'b0, 32'h0, 1'b0);
`endif

        // Random fetches over a small tag set to mix hits and misses
        for (int n = 0; n < 60; n++) begin
            ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            fetch(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 32'h0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
